reg_write_sched: RTL and testbench

- Scheduler for the single write port of the 8-entry LC-3 general register file.
- Arbitrates among NREQ writeback requesters (ALU, memory load, TRAP/JSR link) using round-robin.
- Drives the one-hot register write enable and the write data, one write per cycle.
- Maintains a busy scoreboard of reserved destinations and the NZP condition codes.

---
 rtl/lc3_pkg.sv | 20 ++
 rtl/dec3to8.sv | 10 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/reg_write_sched.sv | 97 +++++++++
 tb/tb_reg_write_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 register-file definitions: register indexing, NZP type and
// the condition-code helper used by the writeback scheduler.
package lc3_pkg;

  localparam int REG_COUNT = 8;
  localparam int REG_IDX_W = 3;
  localparam int WORD_W    = 16;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_RESET = 3'b010;

  // Exactly one of {N,Z,P} is set for any 16-bit word.
  function automatic nzp_t calc_nzp(input logic signed [WORD_W-1:0] data);
    if (data[WORD_W-1])  return 3'b100;
    else if (data == '0) return 3'b010;
    else                 return 3'b001;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable, shared by the register-file write path.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  assign onehot = en ? (8'b1 << idx) : 8'b0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the
// winner only when the grant is actually consumed (advance).
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0]                        req,
  input  logic                                advance,
  output logic [N-1:0]                        grant,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0]  ptr
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic          found;
  logic [PW-1:0] gidx;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_sched.sv
// LC-3 register-file write-port scheduler: round-robin writeback, busy
// scoreboard and NZP. Optional forwarding outputs under REG_WRITE_SCHED_BYPASS_EN.
module reg_write_sched
  import lc3_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*REG_IDX_W-1:0]     req_dr,
  input  logic [NREQ*W-1:0]             req_data,
  input  logic [NREQ-1:0]               req_setcc,
  input  logic                          reserve_valid,
  input  logic [REG_IDX_W-1:0]          reserve_dr,
  output logic [REG_COUNT-1:0]          busy,
  output logic [REG_COUNT-1:0]          rf_we,
  output logic signed [W-1:0]           rf_wdata,
  output nzp_t                          nzp
`ifdef REG_WRITE_SCHED_BYPASS_EN
  ,
  output logic                          byp_valid,
  output logic [REG_IDX_W-1:0]          byp_dr,
  output logic signed [W-1:0]           byp_data
`endif
);

  logic [NREQ-1:0]        grant;
  logic                   xfer_p0;
  logic [REG_IDX_W-1:0]   sel_dr_p0;
  logic signed [W-1:0]    sel_data_p0;
  logic                   sel_setcc_p0;
  logic [REG_COUNT-1:0]   we_dec_p0;
  logic [REG_COUNT-1:0]   rsv_dec_p0;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer_p0),
    .grant   (grant),
    .ptr     ()
  );

  assign req_ready = grant & req_valid;
  assign xfer_p0   = |(req_valid & req_ready);

  always_comb begin
    sel_dr_p0    = '0;
    sel_data_p0  = '0;
    sel_setcc_p0 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_dr_p0    = req_dr[REG_IDX_W*i +: REG_IDX_W];
        sel_data_p0  = req_data[W*i +: W];
        sel_setcc_p0 = req_setcc[i];
      end
    end
  end

  dec3to8 u_we_dec (
    .en     (xfer_p0),
    .idx    (sel_dr_p0),
    .onehot (we_dec_p0)
  );

  dec3to8 u_rsv_dec (
    .en     (reserve_valid),
    .idx    (reserve_dr),
    .onehot (rsv_dec_p0)
  );

  // p0 -> p1: register-file write, NZP and scoreboard update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= '0;
      rf_wdata <= '0;
      nzp      <= NZP_RESET;
      busy     <= '0;
    end else begin
      rf_we <= we_dec_p0;
      if (xfer_p0) rf_wdata <= sel_data_p0;
      if (xfer_p0 && sel_setcc_p0) nzp <= calc_nzp(sel_data_p0);
      // Set is applied after clear so a same-cycle reserve wins.
      busy <= (busy & ~we_dec_p0) | rsv_dec_p0;
    end
  end

`ifdef REG_WRITE_SCHED_BYPASS_EN
  assign byp_valid = xfer_p0;
  assign byp_dr    = sel_dr_p0;
  assign byp_data  = sel_data_p0;
`endif

endmodule

// File: tb/tb_reg_write_sched.sv
// Directed bench for reg_write_sched; REG_WRITE_SCHED_BYPASS_EN adds forwarding checks.
module tb_reg_write_sched;
  import lc3_pkg::*;

  localparam int NREQ = 3;
  localparam int W    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*3-1:0] req_dr;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_setcc;
  logic            reserve_valid;
  logic [2:0]      reserve_dr;
  logic [7:0]      busy;
  logic [7:0]      rf_we;
  logic [W-1:0]    rf_wdata;
  nzp_t            nzp;
`ifdef REG_WRITE_SCHED_BYPASS_EN
  logic            byp_valid;
  logic [2:0]      byp_dr;
  logic [W-1:0]    byp_data;
`endif

  int checks = 0;
  int errors = 0;

  reg_write_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dr        (req_dr),
    .req_data      (req_data),
    .req_setcc     (req_setcc),
    .reserve_valid (reserve_valid),
    .reserve_dr    (reserve_dr),
    .busy          (busy),
    .rf_we         (rf_we),
    .rf_wdata      (rf_wdata),
    .nzp           (nzp)
`ifdef REG_WRITE_SCHED_BYPASS_EN
    ,
    .byp_valid     (byp_valid),
    .byp_dr        (byp_dr),
    .byp_data      (byp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] dr, input logic [W-1:0] data,
                         input logic setcc);
    req_dr[3*i +: 3]   = dr;
    req_data[W*i +: W] = data;
    req_setcc[i]       = setcc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0]   exp_g  [3];
  logic [7:0]   exp_we [3];
  logic [W-1:0] exp_wd [3];

  initial begin
    rst = 1'b1;
    req_valid = '0; req_dr = '0; req_data = '0; req_setcc = '0;
    reserve_valid = 1'b0; reserve_dr = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we",    32'(rf_we),     32'h00);
    chk("rst_busy",     32'(busy),      32'h00);
    chk("rst_nzp",      32'(nzp),       32'b010);
    chk("rst_wdata",    32'(rf_wdata),  32'h0);
    chk("rst_ready",    32'(req_ready), 32'h0);
    rst = 1'b0;
    step();
    chk("idle_rf_we",   32'(rf_we),     32'h00);

    // Single ALU write, negative data
    set_req(0, 3'd3, 16'h8001, 1'b1);
    req_valid = 3'b001;
    #1;
    chk("alu_ready",    32'(req_ready), 32'b001);
`ifdef REG_WRITE_SCHED_BYPASS_EN
    chk("alu_byp_v",    32'(byp_valid), 32'h1);
    chk("alu_byp_dr",   32'(byp_dr),    32'h3);
    chk("alu_byp_d",    32'(byp_data),  32'h8001);
`endif
    step();
    req_valid = '0;
    #1;
    chk("alu_rf_we",    32'(rf_we),     32'h08);
    chk("alu_wdata",    32'(rf_wdata),  32'h8001);
    chk("alu_nzp",      32'(nzp),       32'b100);
`ifdef REG_WRITE_SCHED_BYPASS_EN
    chk("idle_byp_v",   32'(byp_valid), 32'h0);
    chk("idle_byp_d",   32'(byp_data),  32'h0);
`endif
    step();
    chk("idle2_rf_we",  32'(rf_we),     32'h00);
    chk("hold_wdata",   32'(rf_wdata),  32'h8001);

    // LINK write without setcc; pointer is at 1, so it wins
    set_req(2, 3'd7, 16'h3000, 1'b0);
    req_valid = 3'b100;
    #1;
    chk("link_ready",   32'(req_ready), 32'b100);
    step();
    req_valid = '0;
    #1;
    chk("link_rf_we",   32'(rf_we),     32'h80);
    chk("link_wdata",   32'(rf_wdata),  32'h3000);
    chk("link_nzp",     32'(nzp),       32'b100);

    // All three continuously valid; pointer now 0
    set_req(0, 3'd1, 16'h1111, 1'b0);
    set_req(1, 3'd2, 16'h2222, 1'b0);
    set_req(2, 3'd4, 16'h4444, 1'b0);
    exp_g[0] = 3'b001; exp_we[0] = 8'h02; exp_wd[0] = 16'h1111;
    exp_g[1] = 3'b010; exp_we[1] = 8'h04; exp_wd[1] = 16'h2222;
    exp_g[2] = 3'b100; exp_we[2] = 8'h10; exp_wd[2] = 16'h4444;
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(exp_g[i % 3]));
      if (i > 0) begin
        chk($sformatf("rr_we%0d", i), 32'(rf_we),    32'(exp_we[(i - 1) % 3]));
        chk($sformatf("rr_wd%0d", i), 32'(rf_wdata), 32'(exp_wd[(i - 1) % 3]));
      end
      step();
    end
    req_valid = '0;
    #1;
    chk("rr_we_last",   32'(rf_we),     32'h10);
    chk("rr_wd_last",   32'(rf_wdata),  32'h4444);

    // Scoreboard: reserve R5
    reserve_valid = 1'b1; reserve_dr = 3'd5;
    step();
    reserve_valid = 1'b0;
    #1;
    chk("rsv_busy",     32'(busy),      32'h20);

    // LOAD writes zero to R5 with setcc
    set_req(1, 3'd5, 16'h0000, 1'b1);
    req_valid = 3'b010;
    #1;
    chk("ld_ready",     32'(req_ready), 32'b010);
    step();
    req_valid = '0;
    #1;
    chk("ld_busy",      32'(busy),      32'h00);
    chk("ld_nzp",       32'(nzp),       32'b010);
    chk("ld_rf_we",     32'(rf_we),     32'h20);

    // Reserve and write R5 in the same cycle: reserve wins; pointer at 2
    reserve_valid = 1'b1; reserve_dr = 3'd5;
    set_req(0, 3'd5, 16'h0005, 1'b1);
    req_valid = 3'b001;
    #1;
    chk("both_ready",   32'(req_ready), 32'b001);
    step();
    req_valid = '0;
    #1;
    chk("both_busy",    32'(busy),      32'h20);
    chk("both_rf_we",   32'(rf_we),     32'h20);
    chk("both_nzp",     32'(nzp),       32'b001);

    // Re-reserve busy R5 while LINK writes non-busy R2; pointer at 1
    set_req(2, 3'd2, 16'h7fff, 1'b0);
    req_valid = 3'b100;
    #1;
    chk("rr2_ready",    32'(req_ready), 32'b100);
    step();
    req_valid = '0; reserve_valid = 1'b0;
    #1;
    chk("rr2_busy",     32'(busy),      32'h20);
    chk("rr2_rf_we",    32'(rf_we),     32'h04);
    chk("rr2_nzp",      32'(nzp),       32'b001);

    // Mid-operation reset: transfer pending, busy=R5, nzp=P
    set_req(0, 3'd6, 16'h1234, 1'b1);
    req_valid = 3'b001;
    reserve_valid = 1'b1; reserve_dr = 3'd3;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy",    32'(busy),      32'h00);
    chk("mrst_nzp",     32'(nzp),       32'b010);
    chk("mrst_wdata",   32'(rf_wdata),  32'h0);
    chk("mrst_rf_we",   32'(rf_we),     32'h00);
    @(negedge clk);
    chk("mrst_hold_we", 32'(rf_we),     32'h00);
    chk("mrst_hold_bs", 32'(busy),      32'h00);
    req_valid = '0; reserve_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rf_we",   32'(rf_we),     32'h00);
    chk("post_busy",    32'(busy),      32'h00);
    chk("post_wdata",   32'(rf_wdata),  32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
